// File: rtl/aes128_iter_enc_if.sv
// aes128_iter_enc_if: block-in / ciphertext-out handshake bundle for the AES-128 core
interface aes128_iter_enc_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
  modport master (
    output in_valid, data_in, key_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );
  modport slave (
    input  in_valid, data_in, key_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/aes128_iter_enc.sv
// aes128_iter_enc: iterative AES-128 encryptor, ROUNDS_PER_CYCLE chained rounds per clock, keys expanded on the fly
module aes128_iter_enc #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  aes128_iter_enc_if.slave bus
);
  localparam int ITERS = 10 / ROUNDS_PER_CYCLE;
  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
    $error("aes128_iter_enc: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t       state_q, state_d;
  logic [127:0] st_q, rk_q, dout_q, s_fin, k_fin;
  logic [7:0]   rcon_q, rc_fin;
  logic [3:0]   cnt_q;
  logic         accept, last_iter;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = xtime(t);
    end
    return p;
  endfunction
  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    y = a;
    for (int i = 0; i < 6; i++) y = gmul(gmul(y, y), a);
    y = gmul(y, y);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction
  // byte i of the state sits at bits [127-8i -: 8]; row r, column c is byte 4c+r
  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction
  function automatic logic [127:0] mix_cols(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction
  // sw is SubWord(RotWord(w3)) of the previous key
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [31:0] sw, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sw ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_iter = cnt_q == 4'(ITERS - 1);
  for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_rnd
    logic [127:0] s_in, k_in, sb, sr, k_out, s_out;
    logic [31:0]  sw;
    logic [7:0]   rc_in, rc_out;
    logic         last;
    if (r == 0) begin : g_src
      assign s_in  = st_q;
      assign k_in  = rk_q;
      assign rc_in = rcon_q;
    end else begin : g_src
      assign s_in  = g_rnd[r-1].s_out;
      assign k_in  = g_rnd[r-1].k_out;
      assign rc_in = g_rnd[r-1].rc_out;
    end
    for (genvar b = 0; b < 16; b++) begin : g_sb
      assign sb[127-8*b -: 8] = sbox(s_in[127-8*b -: 8]);
    end
    for (genvar b = 0; b < 4; b++) begin : g_ksb
      assign sw[31-8*b -: 8] = sbox(k_in[31-8*((b+1)%4) -: 8]);
    end
    assign k_out  = key_next(k_in, sw, rc_in);
    assign rc_out = xtime(rc_in);
    assign last   = (r == ROUNDS_PER_CYCLE - 1) && last_iter;
    assign sr     = shift_rows(sb);
    assign s_out  = (last ? sr : mix_cols(sr)) ^ k_out;
  end
  assign s_fin  = g_rnd[ROUNDS_PER_CYCLE-1].s_out;
  assign k_fin  = g_rnd[ROUNDS_PER_CYCLE-1].k_out;
  assign rc_fin = g_rnd[ROUNDS_PER_CYCLE-1].rc_out;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state: accept in IDLE, leave RUN on the last iteration, leave DONE on the output handshake
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && accept)        ? RUN  :
              (state_q == RUN && last_iter)      ? DONE :
              (state_q == DONE && bus.out_ready) ? IDLE : state_q;
  end
  // datapath: load on accept, iterate in RUN, capture the ciphertext on the last iteration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
      dout_q <= '0;
    end else if (state_q == IDLE && accept) begin
      st_q   <= bus.data_in ^ bus.key_in;
      rk_q   <= bus.key_in;
      rcon_q <= 8'h01;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      st_q   <= s_fin;
      rk_q   <= k_fin;
      rcon_q <= rc_fin;
      cnt_q  <= cnt_q + 4'd1;
      if (last_iter) dout_q <= s_fin;
    end
  end
  assign bus.in_ready  = state_q == IDLE && !rst;
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  assign bus.data_out  = dout_q;
endmodule

// File: tb/tb_aes128_iter_enc.sv
// tb_aes128_iter_enc: known-answer, latency, backpressure, back-to-back and abort checks at RPC 1/2/5/10
module tb_aes128_iter_enc;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic [3:0]   ov, ir, bz;
  logic [127:0] dout [4];
  int           tests = 0;
  int           failed = 0;
  int           rpc [4] = '{1, 2, 5, 10};
  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t vecs [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_iter_enc_if ifc ();
    assign ifc.in_valid  = in_valid;
    assign ifc.out_ready = out_ready;
    assign ifc.data_in   = data_in;
    assign ifc.key_in    = key_in;
    aes128_iter_enc #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
    assign ov[g]   = ifc.out_valid;
    assign ir[g]   = ifc.in_ready;
    assign bz[g]   = ifc.busy;
    assign dout[g] = ifc.data_out;
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic submit(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    key_in   = k;
    data_in  = p;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    key_in   = ~k;
    data_in  = ~p;
  endtask
  task automatic wait0(output int lat);
    lat = 0;
    for (int n = 1; n <= 30 && lat == 0; n++) begin
      @(negedge clk);
      if (ov[0]) lat = n;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int           lat [4];
    int           l0, got, seen;
    logic         pend;
    logic [127:0] snap;
    vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{"fips_b", 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[2] = '{"zero", 128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    #12;
    chk("rst_in_ready", 128'(ir), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(ir), 128'hf);
    chk("idle_out_valid", 128'(ov), 128'h0);
    chk("idle_busy", 128'(bz), 128'h0);
    chk("idle_data_out", dout[0], 128'h0);
    for (int v = 0; v < 3; v++) begin
      submit(vecs[v].key, vecs[v].pt);
      for (int g = 0; g < 4; g++) lat[g] = 0;
      for (int n = 1; n <= 12; n++) begin
        @(negedge clk);
        for (int g = 0; g < 4; g++) if (ov[g] && lat[g] == 0) lat[g] = n;
      end
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("%s_lat_rpc%0d", vecs[v].name, rpc[g]), 128'(lat[g]), 128'(10 / rpc[g]));
        chk($sformatf("%s_ct_rpc%0d", vecs[v].name, rpc[g]), dout[g], vecs[v].ct);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("%s_back_idle", vecs[v].name), 128'(ir), 128'hf);
    end
    submit(vecs[0].key, vecs[0].pt);
    wait0(l0);
    chk("bp_lat", 128'(l0), 128'd10);
    snap = dout[0];
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_%0d", n), dout[0], snap);
      chk($sformatf("bp_in_ready_%0d", n), {127'h0, ir[0]}, 128'h0);
    end
    chk("bp_ct", snap, vecs[0].ct);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", {127'h0, ir[0]}, 128'h1);
    chk("bp_release_out_valid", {127'h0, ov[0]}, 128'h0);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    key_in   = vecs[0].key;
    data_in  = vecs[0].pt;
    @(posedge clk);
    @(negedge clk);
    key_in  = vecs[1].key;
    data_in = vecs[1].pt;
    got  = 0;
    pend = 1'b0;
    for (int n = 1; n <= 40 && got < 2; n++) begin
      @(negedge clk);
      if (pend) begin
        in_valid = 1'b0;
        key_in   = '1;
        data_in  = '0;
        pend     = 1'b0;
      end
      if (ov[0]) begin
        got++;
        chk($sformatf("b2b_ct_%0d", got), dout[0], got == 1 ? vecs[0].ct : vecs[1].ct);
      end
      if (ir[0] && in_valid) pend = 1'b1;
    end
    chk("b2b_count", 128'(got), 128'd2);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    submit(vecs[0].key, vecs[0].pt);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", 128'(ov), 128'h0);
    chk("abort_busy", 128'(bz), 128'h0);
    chk("abort_in_ready", 128'(ir), 128'h0);
    chk("abort_data_out", dout[0], 128'h0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (|ov) seen++;
    end
    chk("abort_no_output", 128'(seen), 128'h0);
    submit(vecs[0].key, vecs[0].pt);
    wait0(l0);
    chk("abort_new_lat", 128'(l0), 128'd10);
    chk("abort_new_ct", dout[0], vecs[0].ct);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/aes128_iter_enc.md
Name: aes128_iter_enc

Overview:
- Parametrised AES-128 encryption core with ready/valid handshakes on input and output.
- Replaces the fully unrolled 10-stage round chain with a loop of ROUNDS_PER_CYCLE round datapaths, reused over 10/ROUNDS_PER_CYCLE cycles.
- Round keys are expanded on the fly. There is no key RAM.
- Sits between the block-mode/controller logic and the result consumer. One block is in flight at a time.

Parameters:
- ROUNDS_PER_CYCLE, 1: number of AES rounds evaluated per clock. Legal values are 1, 2, 5 and 10. Any other value is an elaboration error.
- ITERS, 10/ROUNDS_PER_CYCLE: derived localparam (not overridable). Number of RUN cycles per block.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  data_in/key_in valid
- in_ready  out  1  core accepts a block this cycle
- data_in  in  128  plaintext, byte 0 = bits [127:120] (FIPS-197 order)
- key_in  in  128  cipher key, same byte order
- out_valid  out  1  data_out holds a finished ciphertext
- out_ready  in  1  consumer takes data_out this cycle
- data_out  out  128  ciphertext, registered
- busy  out  1  high in RUN and DONE

Behaviour:
- Reset: asynchronous and active-high. While rst=1 the core forces:
  - state=IDLE, state register=0, round key=0, rcon=8'h01, round counter=0
  - out_valid=0, data_out=0, busy=0, in_ready=0
- After rst deasserts: in_ready=1 from the first cycle in IDLE.
- in_ready = (state==IDLE). It is registered-state derived and has no combinational path from out_ready.
- IDLE:
  - On in_valid&&in_ready, capture st <= data_in ^ key_in and rk <= key_in.
  - Set rcon=8'h01 and cnt=0, then go to RUN.
  - in_valid without in_ready is ignored. The source must hold its data.
- RUN: each cycle applies ROUNDS_PER_CYCLE rounds combinationally, chained.
  - Each round does SubBytes, ShiftRows, MixColumns and AddRoundKey with the next round key.
  - The round key is produced by the standard AES-128 expansion from the previous rk and the current rcon.
  - After each round, rcon <= xtime(rcon), i.e. 01,02,04,08,10,20,40,80,1b,36.
  - The round with global index 10 omits MixColumns.
  - cnt increments by 1 per cycle. On the cycle with cnt==ITERS-1, the final result loads data_out, out_valid goes to 1 and the state moves to DONE.
- DONE: data_out and out_valid hold until out_valid&&out_ready. On that edge out_valid goes to 0 and the state returns to IDLE.
- Latency: a block accepted on edge k gives out_valid=1 after edge k+ITERS.
- Throughput: one block per ITERS+2 cycles when out_ready is tied high.
- S-box: use the existing shared S-box. ROUNDS_PER_CYCLE×20 S-box instances are needed (16 for data, 4 for the key schedule).
- Boundaries:
  - in_valid held high across DONE is not accepted until the core re-enters IDLE.
  - out_ready asserted while out_valid=0 has no effect.
  - Reset mid-RUN or mid-DONE aborts the block. No partial output and no out_valid pulse.
  - key_in and data_in changing after acceptance do not affect the block in flight.
- busy=1 exactly in RUN and DONE.

Test Plan:
- Reset then idle: rst pulse with in_valid=0 → in_ready=1, out_valid=0, data_out=0, busy=0. Assert rst asynchronously mid-cycle → outputs clear before the next edge.
- FIPS-197 C.1, RPC=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → data_out=69c4e0d86a7b0430d8cdb78070b4c55a with out_valid rising exactly 10 cycles after the accept edge.
- FIPS-197 App. B, run separately at RPC=1, 2, 5 and 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32 with latency 10, 5, 2 and 1 respectively.
- Output backpressure: out_ready=0 for 7 cycles after out_valid rises → data_out stable, in_ready=0 throughout. Then out_ready=1 → handshake completes, in_ready=1 the next cycle.
- Back-to-back blocks: in_valid held high with C.1 then App. B vectors, out_ready=1 → both ciphertexts appear in order, each accepted only when in_ready=1. Changing inputs during RUN does not alter the result.
- Abort: assert rst at RUN cycle 4 (RPC=1), release, submit C.1 → no output from the aborted block, correct C.1 ciphertext from the new one.
